// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared DDS types and default widths
// Purpose: state encoding for the phase accumulator and the default widths
//   that the waveform stages must agree with.
// Ports: none (package).
package dds_pkg;

  localparam int DDS_ACC_WIDTH    = 32;
  localparam int DDS_PA_OUT_WIDTH = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } dds_state_t;

endpackage

// File: rtl/dds_ftw_buffer.sv
// rtl/dds_ftw_buffer.sv - FTW handshake, pending register and active tuning word
// Purpose: accepts a new frequency tuning word and either applies it on the
//   next edge or parks it until the controller signals a commit.
// Ports:
//   clk, rst          clock, async active-high reset
//   ftw_in_i          new tuning word
//   ftw_valid_i       ftw_in_i valid
//   pend_state_i      controller is holding a pending word (blocks new words)
//   defer_i           an accepted word goes to the pending register
//   commit_i          copy the pending word into the active word
//   ftw_ready_o       handshake ready
//   ftw_accept_o      transfer happens this cycle
//   ftw_active_o      tuning word used by the accumulator
module dds_ftw_buffer #(
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ACC_WIDTH-1:0] ftw_in_i,
  input  logic                 ftw_valid_i,
  input  logic                 pend_state_i,
  input  logic                 defer_i,
  input  logic                 commit_i,
  output logic                 ftw_ready_o,
  output logic                 ftw_accept_o,
  output logic [ACC_WIDTH-1:0] ftw_active_o
);

  logic [ACC_WIDTH-1:0] active_q, active_d;
  logic [ACC_WIDTH-1:0] pend_q, pend_d;

  assign ftw_ready_o  = ~pend_state_i;
  assign ftw_accept_o = ftw_valid_i & ftw_ready_o;
  assign ftw_active_o = active_q;

  always_comb begin
    active_d = active_q;
    pend_d   = pend_q;
    if (ftw_accept_o) begin
      if (defer_i) pend_d   = ftw_in_i;
      else         active_d = ftw_in_i;
    end
    // Commit only occurs while pending, when no new word can be accepted.
    if (commit_i) active_d = pend_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= '0;
      pend_q   <= '0;
    end else begin
      active_q <= active_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: rtl/dds_phase_accum.sv
// rtl/dds_phase_accum.sv - DDS phase accumulator with glitch-free FTW update
// Purpose: accumulates the active FTW each enabled cycle, truncates and adds a
//   phase offset, and emits registered phase with valid and wrap strobes.
// Ports:
//   clk, rst      clock, async active-high reset
//   en            accumulate enable
//   phase_clr     synchronous accumulator clear
//   ftw_in        new tuning word; ftw_valid/ftw_ready handshake
//   poff_in       phase offset, loaded when poff_valid
//   phase_value   truncated phase plus offset
//   phase_valid   phase_value updated this cycle
//   wrap          phase_value is the first sample after accumulator carry-out
module dds_phase_accum
  import dds_pkg::*;
#(
  parameter int ACC_WIDTH      = DDS_ACC_WIDTH,
  parameter int PA_OUT_WIDTH   = DDS_PA_OUT_WIDTH,
  parameter bit UPDATE_ON_WRAP = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    phase_clr,
  input  logic [ACC_WIDTH-1:0]    ftw_in,
  input  logic                    ftw_valid,
  output logic                    ftw_ready,
  input  logic [PA_OUT_WIDTH-1:0] poff_in,
  input  logic                    poff_valid,
  output logic [PA_OUT_WIDTH-1:0] phase_value,
  output logic                    phase_valid,
  output logic                    wrap
);

  dds_state_t state_q, state_d;

  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                    carry_q;
  logic                    stepped_q;
  logic [PA_OUT_WIDTH-1:0] poff_q;
  logic [PA_OUT_WIDTH-1:0] phase_q;
  logic                    valid_q;
  logic                    wrap_q;

  logic [ACC_WIDTH-1:0] ftw_active;
  logic                 ftw_accept;
  logic                 step;
  logic                 carry;
  logic [ACC_WIDTH-1:0] sum;
  logic                 defer;
  logic                 commit;

  // A clear overrides the step, so it never produces a carry.
  assign step         = en & ~phase_clr;
  assign {carry, sum} = {1'b0, acc_q} + {1'b0, ftw_active};

  // Defer only while actually stepping; otherwise no step can see a mixed word.
  assign defer  = UPDATE_ON_WRAP && (state_q == RUN) && en && !phase_clr;
  assign commit = (state_q == PEND) && (!en || phase_clr || (step && carry));

  dds_ftw_buffer #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_ftw_buffer (
    .clk          (clk),
    .rst          (rst),
    .ftw_in_i     (ftw_in),
    .ftw_valid_i  (ftw_valid),
    .pend_state_i (state_q == PEND),
    .defer_i      (defer),
    .commit_i     (commit),
    .ftw_ready_o  (ftw_ready),
    .ftw_accept_o (ftw_accept),
    .ftw_active_o (ftw_active)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (en) state_d = RUN;
      RUN: begin
        if (!en)                    state_d = IDLE;
        else if (ftw_accept && defer) state_d = PEND;
      end
      PEND: begin
        if (!en)        state_d = IDLE;
        else if (commit) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (phase_clr)  acc_d = '0;
    else if (step)  acc_d = sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      stepped_q <= 1'b0;
      poff_q    <= '0;
      phase_q   <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      carry_q   <= step & carry;
      // An enabled clear counts as an accumulator update for the output stage.
      stepped_q <= en;
      if (poff_valid) poff_q <= poff_in;
      valid_q   <= stepped_q;
      wrap_q    <= stepped_q & carry_q;
      if (stepped_q) phase_q <= acc_q[ACC_WIDTH-1 -: PA_OUT_WIDTH] + poff_q;
    end
  end

  assign phase_value = phase_q;
  assign phase_valid = valid_q;
  assign wrap        = wrap_q;

endmodule
